// File: rtl/rwt_pack_stream_arbiter_if.sv
// Stream bundle around the arbiter: NUM_SRC sample sources in, one tagged stream out.
// slave = arbiter side, master = the sources and packer that surround it.
interface rwt_pack_stream_arbiter_if #(
    parameter int NUM_SRC  = 4,
    parameter int UWIDTH   = 1,
    parameter int ID_WIDTH = 3
);
    logic [NUM_SRC-1:0]        s_axi_valid;
    logic [NUM_SRC-1:0]        s_axi_ready;
    logic [4*NUM_SRC-1:0]      s_axi_enables;
    logic [64*NUM_SRC-1:0]     s_axi_data;
    logic [UWIDTH*NUM_SRC-1:0] s_axi_user;
    logic [NUM_SRC-1:0]        s_axi_last;
    logic                      m_axi_ready;
    logic                      m_axi_valid;
    logic [3:0]                m_axi_enables;
    logic [63:0]               m_axi_data;
    logic [UWIDTH-1:0]         m_axi_user;
    logic                      m_axi_last;
    logic [ID_WIDTH-1:0]       m_axi_id;

    modport slave (
        input  s_axi_valid, s_axi_enables, s_axi_data, s_axi_user, s_axi_last, m_axi_ready,
        output s_axi_ready, m_axi_valid, m_axi_enables, m_axi_data, m_axi_user, m_axi_last, m_axi_id
    );

    modport master (
        output s_axi_valid, s_axi_enables, s_axi_data, s_axi_user, s_axi_last, m_axi_ready,
        input  s_axi_ready, m_axi_valid, m_axi_enables, m_axi_data, m_axi_user, m_axi_last, m_axi_id
    );
endinterface

// File: rtl/rwt_pack_stream_arbiter.sv
// Packet-atomic round-robin arbiter feeding the sample packer through one output register.
// Optional per-source packet counters when RWT_PACK_ARB_STATS_EN is defined.
module rwt_pack_stream_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int UWIDTH   = 1,
    parameter int ID_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [NUM_SRC-1:0]   cfg_src_mask,
    rwt_pack_stream_arbiter_if.slave bus,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy
`ifdef RWT_PACK_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [32*NUM_SRC-1:0] stat_pkt_cnt
`endif
);
    localparam int NSLOT = 1 << ID_WIDTH;

    typedef enum logic {ST_IDLE, ST_LOCK} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0] gidx_q, gidx_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0] pick;

    logic                m_valid_q, m_valid_d;
    logic                m_last_q;
    logic [3:0]          m_en_q;
    logic [63:0]         m_data_q;
    logic [UWIDTH-1:0]   m_user_q;
    logic [ID_WIDTH-1:0] m_id_q;

    logic [NSLOT-1:0]    slot_valid;
    logic [NSLOT-1:0]    slot_last;
    logic [3:0]          slot_en   [NSLOT];
    logic [63:0]         slot_data [NSLOT];
    logic [UWIDTH-1:0]   slot_user [NSLOT];

    logic [NUM_SRC-1:0]  req;
    logic                lock_ready;
    logic                load;
    logic                pkt_done;

    // Scan last+1 .. last (wrapping); descending loop so the nearest requester wins.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                    input logic [ID_WIDTH-1:0] last);
        logic [ID_WIDTH-1:0] p;
        int                  idx;
        p = last;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (|(r & (NUM_SRC'(1) << idx))) p = ID_WIDTH'(idx);
        end
        return p;
    endfunction

    // Slots beyond NUM_SRC read as idle so the owner index can select without range issues.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NUM_SRC) begin : g_src
            assign slot_valid[gi]      = bus.s_axi_valid[gi];
            assign slot_last[gi]       = bus.s_axi_last[gi];
            assign slot_en[gi]         = bus.s_axi_enables[4*gi +: 4];
            assign slot_data[gi]       = bus.s_axi_data[64*gi +: 64];
            assign slot_user[gi]       = bus.s_axi_user[UWIDTH*gi +: UWIDTH];
            assign bus.s_axi_ready[gi] = lock_ready && (gidx_q == ID_WIDTH'(gi));
        end else begin : g_pad
            assign slot_valid[gi] = 1'b0;
            assign slot_last[gi]  = 1'b0;
            assign slot_en[gi]    = '0;
            assign slot_data[gi]  = '0;
            assign slot_user[gi]  = '0;
        end
    end

    assign req        = bus.s_axi_valid & cfg_src_mask;
    assign pick       = rr_pick(req, last_grant_q);
    assign lock_ready = (state_q == ST_LOCK) && (!m_valid_q || bus.m_axi_ready);
    assign load       = lock_ready && slot_valid[gidx_q];
    assign pkt_done   = load && slot_last[gidx_q];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_LOCK;
                    gidx_d  = pick;
                    grant_d = NUM_SRC'(1) << pick;
                end
            end
            ST_LOCK: begin
                // The mask is not consulted here: a started packet always completes.
                if (pkt_done) begin
                    state_d      = ST_IDLE;
                    last_grant_d = gidx_q;
                    grant_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_valid_d = load || (m_valid_q && !bus.m_axi_ready);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_WIDTH'(NUM_SRC - 1);
            gidx_q       <= '0;
            grant_q      <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_en_q       <= '0;
            m_data_q     <= '0;
            m_user_q     <= '0;
            m_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            m_valid_q    <= m_valid_d;
            if (load) begin
                m_last_q <= slot_last[gidx_q];
                m_en_q   <= slot_en[gidx_q];
                m_data_q <= slot_data[gidx_q];
                m_user_q <= slot_user[gidx_q];
                m_id_q   <= gidx_q;
            end
        end
    end

    assign bus.m_axi_valid   = m_valid_q;
    assign bus.m_axi_last    = m_last_q;
    assign bus.m_axi_enables = m_en_q;
    assign bus.m_axi_data    = m_data_q;
    assign bus.m_axi_user    = m_user_q;
    assign bus.m_axi_id      = m_id_q;
    assign grant             = grant_q;
    assign busy              = (state_q == ST_LOCK) || m_valid_q;

`ifdef RWT_PACK_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stat
        logic [31:0] cnt_q;
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else if (stat_clr) begin
                cnt_q <= '0;
            end else if (pkt_done && (gidx_q == ID_WIDTH'(gi))) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign stat_pkt_cnt[32*gi +: 32] = cnt_q;
    end
`endif
endmodule

// File: tb/tb_rwt_pack_stream_arbiter.sv
// Bench for rwt_pack_stream_arbiter: queue-driven sources, expected-beat scoreboard on the output.
// Table rows describe packet mixes and the grant order they must produce.
module tb_rwt_pack_stream_arbiter;
    localparam int NS = 4;
    localparam int UW = 1;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NS-1:0] cfg_src_mask = '1;
    logic [NS-1:0] grant;
    logic          busy;
`ifdef RWT_PACK_ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [32*NS-1:0] stat_pkt_cnt;
`endif

    always #5 clk = ~clk;

    rwt_pack_stream_arbiter_if #(.NUM_SRC(NS), .UWIDTH(UW), .ID_WIDTH(IW)) bus ();

    rwt_pack_stream_arbiter #(.NUM_SRC(NS), .UWIDTH(UW), .ID_WIDTH(IW)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .cfg_src_mask (cfg_src_mask),
        .bus          (bus),
        .grant        (grant),
        .busy         (busy)
`ifdef RWT_PACK_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_pkt_cnt (stat_pkt_cnt)
`endif
    );

    typedef struct packed {
        logic        bubble;
        logic        last;
        logic [3:0]  en;
        logic [63:0] data;
        logic [0:0]  user;
    } sbeat_t;

    typedef struct packed {
        logic [2:0]  id;
        logic        last;
        logic [3:0]  en;
        logic [63:0] data;
        logic [0:0]  user;
    } obeat_t;

    typedef struct packed {
        logic [3:0]      srcs;
        logic [1:0]      src0_pkts;
        logic [3:0]      nb;
        logic            tgl;
        logic [3:0]      en;
        logic [2:0]      n_exp;
        logic [4:0][1:0] ord;
    } vec_t;

    sbeat_t src_q[NS][$];
    obeat_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     beats_seen = 0;
    bit     ready_tgl = 1'b0;
    vec_t   vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_data(input int s, input int v, input int p, input int b);
        return {16'(s), 16'(v), 16'(p), 16'(b)};
    endfunction

    task automatic push_src(input int s, input int v, input int p, input int nb,
                            input logic [3:0] en, input int gap_at, input int gap_len);
        sbeat_t b;
        for (int i = 0; i < nb; i++) begin
            b = '{bubble: 1'b0, last: (i == nb - 1), en: en, data: mk_data(s, v, p, i), user: 1'(i)};
            src_q[s].push_back(b);
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    b = '0;
                    b.bubble = 1'b1;
                    src_q[s].push_back(b);
                end
            end
        end
    endtask

    task automatic push_exp(input int s, input int v, input int p, input int nb, input logic [3:0] en);
        obeat_t e;
        for (int i = 0; i < nb; i++) begin
            e = '{id: 3'(s), last: (i == nb - 1), en: en, data: mk_data(s, v, p, i), user: 1'(i)};
            exp_q.push_back(e);
        end
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0 && !src_q[i][0].bubble) begin
                bus.s_axi_valid[i]         = 1'b1;
                bus.s_axi_last[i]          = src_q[i][0].last;
                bus.s_axi_enables[4*i +: 4] = src_q[i][0].en;
                bus.s_axi_data[64*i +: 64] = src_q[i][0].data;
                bus.s_axi_user[i]          = src_q[i][0].user[0];
            end else begin
                bus.s_axi_valid[i]         = 1'b0;
                bus.s_axi_last[i]          = 1'b0;
                bus.s_axi_enables[4*i +: 4] = 4'h0;
                bus.s_axi_data[64*i +: 64] = 64'h0;
                bus.s_axi_user[i]          = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (!(exp_q.size() == 0 && srcs_empty() && !busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", name}, 128'(n < max), 128'(1));
    endtask

    // Source driver: retire accepted beats and bubbles, then present the next queue heads.
    initial begin : driver
        logic [NS-1:0] acc;
        bus.m_axi_ready = 1'b1;
        drive_srcs();
        forever begin
            @(negedge clk);
            acc = bus.s_axi_valid & bus.s_axi_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() > 0 && (acc[i] || src_q[i][0].bubble)) void'(src_q[i].pop_front());
            end
            drive_srcs();
            bus.m_axi_ready = ready_tgl ? ~bus.m_axi_ready : 1'b1;
        end
    end

    // Output monitor and ready-rule check, sampled mid-cycle.
    initial begin : monitor
        obeat_t got;
        obeat_t e;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                for (int i = 0; i < NS; i++) begin
                    chk($sformatf("s_ready%0d", i), 128'(bus.s_axi_ready[i]),
                        128'(grant[i] & (~bus.m_axi_valid | bus.m_axi_ready)));
                end
                if (bus.m_axi_valid && bus.m_axi_ready) begin
                    got = '{id: bus.m_axi_id, last: bus.m_axi_last, en: bus.m_axi_enables,
                            data: bus.m_axi_data, user: bus.m_axi_user};
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 128'(got), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 128'(got), 128'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mkvec(input logic [3:0] srcs, input int p0, input int nb, input bit tgl,
                                   input logic [3:0] en, input int n_exp, input logic [4:0][1:0] ord);
        vec_t v;
        v.srcs = srcs; v.src0_pkts = 2'(p0); v.nb = 4'(nb); v.tgl = tgl;
        v.en = en; v.n_exp = 3'(n_exp); v.ord = ord;
        return v;
    endfunction

    initial begin : main
        int n;
        int t0;
        int occ[NS];
        int s;
        // ord packed as {e4,e3,e2,e1,e0}; e0 is the first grant.
        vecs[0] = mkvec(4'b1111, 2, 2, 1'b0, 4'hF, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        vecs[1] = mkvec(4'b0001, 1, 3, 1'b0, 4'h3, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
        vecs[2] = mkvec(4'b0110, 1, 1, 1'b0, 4'hC, 2, {2'd0, 2'd0, 2'd0, 2'd2, 2'd1});
        vecs[3] = mkvec(4'b1001, 1, 1, 1'b0, 4'h5, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3});
        vecs[4] = mkvec(4'b0010, 1, 8, 1'b1, 4'hF, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1});
        vecs[5] = mkvec(4'b0100, 1, 2, 1'b0, 4'h0, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2});

        repeat (3) @(negedge clk);
        chk("rst_m_valid", 128'(bus.m_axi_valid), 128'(0));
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_s_ready", 128'(bus.s_axi_ready), 128'(0));
        chk("rst_m_data", 128'(bus.m_axi_data), 128'(0));
        aresetn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            ready_tgl = vecs[v].tgl;
            for (int i = 0; i < NS; i++) begin
                occ[i] = 0;
                if (vecs[v].srcs[i]) begin
                    for (int p = 0; p < ((i == 0) ? int'(vecs[v].src0_pkts) : 1); p++)
                        push_src(i, 100 + v, p, int'(vecs[v].nb), vecs[v].en, -1, 0);
                end
            end
            for (int k = 0; k < int'(vecs[v].n_exp); k++) begin
                s = int'(vecs[v].ord[k]);
                push_exp(s, 100 + v, occ[s], int'(vecs[v].nb), vecs[v].en);
                occ[s]++;
            end
            wait_drain($sformatf("vec%0d", v), 600);
            ready_tgl = 1'b0;
            chk($sformatf("vec%0d_grant_idle", v), 128'(grant), 128'(0));
            $display("vector %0d done, beats seen so far %0d", v, beats_seen);
        end

        // Idle-to-output latency and back-to-back beats inside a packet.
        push_src(0, 1, 0, 3, 4'hF, -1, 0);
        push_exp(0, 1, 0, 3, 4'hF);
        n = 0;
        while (!bus.s_axi_valid[0] && n < 20) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (!bus.m_axi_valid && n < 20) begin @(negedge clk); n++; end
        chk("lat_idle", 128'(cyc - t0), 128'(2));
        @(negedge clk);
        chk("contig_b1", 128'(bus.m_axi_valid), 128'(1));
        @(negedge clk);
        chk("contig_b2_last", 128'({bus.m_axi_valid, bus.m_axi_last}), 128'(2'b11));
        wait_drain("lat", 100);
        chk("lat_grant_idle", 128'(grant), 128'(0));

        // Owner stalls mid-packet: lock held, competitor waits.
        push_src(1, 3, 0, 4, 4'hA, 1, 5);
        push_exp(1, 3, 0, 4, 4'hA);
        n = 0;
        while (grant != 4'b0010 && n < 20) begin @(negedge clk); n++; end
        push_src(2, 3, 0, 2, 4'hB, -1, 0);
        push_exp(2, 3, 0, 2, 4'hB);
        n = 0;
        while (!(bus.s_axi_valid[1] == 1'b0 && bus.s_axi_valid[2] && grant == 4'b0010) && n < 20) begin
            @(negedge clk); n++;
        end
        chk("stall_seen", 128'(n < 20), 128'(1));
        chk("stall_grant", 128'(grant), 128'(4'b0010));
        chk("stall_no_src2", 128'(bus.s_axi_ready[2]), 128'(0));
        wait_drain("stall", 200);

        // Masked requester never wins until its bit is set.
        cfg_src_mask = 4'b1011;
        push_src(2, 5, 0, 2, 4'h6, -1, 0);
        repeat (8) @(negedge clk);
        chk("mask_busy", 128'(busy), 128'(0));
        chk("mask_grant", 128'(grant), 128'(0));
        chk("mask_m_valid", 128'(bus.m_axi_valid), 128'(0));
        push_exp(2, 5, 0, 2, 4'h6);
        cfg_src_mask = 4'b1111;
        n = 0;
        while (grant != 4'b0100 && n < 10) begin @(negedge clk); n++; end
        chk("mask_release_grant", 128'(grant), 128'(4'b0100));
        wait_drain("mask", 100);

        // Reset in the middle of a packet.
        push_src(3, 6, 0, 6, 4'hF, -1, 0);
        push_exp(3, 6, 0, 6, 4'hF);
        n = 0;
        while (!(bus.m_axi_valid && bus.m_axi_id == 3'd3) && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("arst_m_valid", 128'(bus.m_axi_valid), 128'(0));
        chk("arst_grant", 128'(grant), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_out", 128'({bus.m_axi_data, bus.m_axi_last, bus.m_axi_id}), 128'(0));
        exp_q.delete();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        push_src(3, 7, 0, 2, 4'h1, -1, 0);
        push_src(1, 7, 0, 2, 4'h1, -1, 0);
        push_exp(1, 7, 0, 2, 4'h1);
        push_exp(3, 7, 0, 2, 4'h1);
        wait_drain("post_rst", 100);

`ifdef RWT_PACK_ARB_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push_src(3, 8, p, 1, 4'h2, -1, 0);
            push_exp(3, 8, p, 1, 4'h2);
        end
        wait_drain("stats", 100);
        chk("stat_src3", 128'(stat_pkt_cnt[127:96]), 128'(3));
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr", 128'(stat_pkt_cnt[127:96]), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
